// File: rtl/alu_pkg.sv
// Shared types and funct codes for the 32-bit R-type ALU.
// Shift decode is present only when ALU_SHIFT_EN is defined.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int FUNCT_W = 6;
  localparam int SHAMT_W = 5;

  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [FUNCT_W-1:0] FN_SLTU = 6'b101011;
  localparam logic [FUNCT_W-1:0] FN_SLLV = 6'b000100;
  localparam logic [FUNCT_W-1:0] FN_SRLV = 6'b000110;
  localparam logic [FUNCT_W-1:0] FN_SRAV = 6'b000111;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_SHIFT,
    OP_BAD
  } op_e;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shift_e;

  typedef struct packed {
    op_e    op;
    logic   chk_ovf;
    shift_e sh;
  } dec_t;

  function automatic dec_t decode(input logic [FUNCT_W-1:0] f);
    dec_t d;
    d.op      = OP_BAD;
    d.chk_ovf = 1'b0;
    d.sh      = SH_LL;
    unique case (1'b1)
      (f == FN_ADD):  begin d.op = OP_ADD; d.chk_ovf = 1'b1; end
      (f == FN_ADDU): d.op = OP_ADD;
      (f == FN_SUB):  begin d.op = OP_SUB; d.chk_ovf = 1'b1; end
      (f == FN_SUBU): d.op = OP_SUB;
      (f == FN_AND):  d.op = OP_AND;
      (f == FN_OR):   d.op = OP_OR;
      (f == FN_XOR):  d.op = OP_XOR;
      (f == FN_NOR):  d.op = OP_NOR;
      (f == FN_SLT):  d.op = OP_SLT;
      (f == FN_SLTU): d.op = OP_SLTU;
`ifdef ALU_SHIFT_EN
      (f == FN_SLLV): begin d.op = OP_SHIFT; d.sh = SH_LL; end
      (f == FN_SRLV): begin d.op = OP_SHIFT; d.sh = SH_RL; end
      (f == FN_SRAV): begin d.op = OP_SHIFT; d.sh = SH_RA; end
`endif
      default:        d.op = OP_BAD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter for sllv/srlv/srav.
// Left shifts reuse the right-shift stages on a bit-reversed word.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_e             sh,
  output logic [DATA_W-1:0]  result
);

  function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = x[DATA_W-1-i];
    end
    return r;
  endfunction

  logic              is_left;
  logic              fill;
  logic [DATA_W-1:0] stage [SHAMT_W+1];

  assign is_left  = (sh == SH_LL);
  assign fill     = (sh == SH_RA) & data[DATA_W-1];
  assign stage[0] = is_left ? rev(data) : data;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int S = 1 << i;
    assign stage[i+1] = shamt[i]
      ? {{S{fill}}, stage[i][DATA_W-1:S]}
      : stage[i];
  end

  assign result = is_left ? rev(stage[SHAMT_W]) : stage[SHAMT_W];

endmodule

// File: rtl/alu.sv
// Single-cycle registered 32-bit R-type ALU with zero/overflow/invalid flags.
// Define ALU_SHIFT_EN to decode sllv/srlv/srav and build alu_shifter.
module alu
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  read_data_1,
  input  logic [DATA_W-1:0]  read_data_2,
  input  logic [FUNCT_W-1:0] functionField,
  output logic [DATA_W-1:0]  aluResult,
  output logic               zero,
  output logic               overflow,
  output logic               invalid
);

  dec_t              dec;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] sum;
  logic              is_sub;
  logic              sum_ovf;
  logic [DATA_W-1:0] shift_res;
  logic [DATA_W-1:0] res_nxt;
  logic              ovf_nxt;
  logic              inv_nxt;

  assign dec = decode(functionField);
  assign a   = read_data_1;
  assign b   = read_data_2;

  // Subtract as A + ~B + 1; overflow when the effective operands
  // share a sign that the sum does not.
  assign is_sub  = (dec.op == OP_SUB);
  assign b_eff   = is_sub ? ~b : b;
  assign sum     = a + b_eff + {{(DATA_W-1){1'b0}}, is_sub};
  assign sum_ovf = (a[DATA_W-1] == b_eff[DATA_W-1])
                 & (sum[DATA_W-1] != a[DATA_W-1]);

`ifdef ALU_SHIFT_EN
  alu_shifter u_shifter (
    .data   (b),
    .shamt  (a[SHAMT_W-1:0]),
    .sh     (dec.sh),
    .result (shift_res)
  );
`else
  assign shift_res = '0;
`endif

  always_comb begin
    res_nxt = '0;
    ovf_nxt = 1'b0;
    inv_nxt = 1'b0;
    unique case (dec.op)
      OP_ADD, OP_SUB: begin
        res_nxt = sum;
        ovf_nxt = dec.chk_ovf & sum_ovf;
      end
      OP_AND:   res_nxt = a & b;
      OP_OR:    res_nxt = a | b;
      OP_XOR:   res_nxt = a ^ b;
      OP_NOR:   res_nxt = ~(a | b);
      OP_SLT:   res_nxt = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:  res_nxt = {{(DATA_W-1){1'b0}}, a < b};
      OP_SHIFT: res_nxt = shift_res;
      default:  inv_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aluResult <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      aluResult <= res_nxt;
      zero      <= (res_nxt == '0);
      overflow  <= ovf_nxt;
      invalid   <= inv_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus queues expected outputs,
// a monitor pops them after each edge and checks they hold.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [5:0]  functionField;
  logic [31:0] aluResult;
  logic        zero;
  logic        overflow;
  logic        invalid;

  int total = 0;
  int bad   = 0;

  logic [34:0] exp_q [$];
  string       name_q [$];

  alu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_data_1   (read_data_1),
    .read_data_2   (read_data_2),
    .functionField (functionField),
    .aluResult     (aluResult),
    .zero          (zero),
    .overflow      (overflow),
    .invalid       (invalid)
  );

  always #5 clk = ~clk;

  // Inputs change 3 time units after an edge; the next edge captures them.
  task automatic issue(input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] f,
                       input logic [31:0] er, input logic eo,
                       input logic ei, input string nm);
    @(posedge clk);
    #3;
    rst_n         = r;
    read_data_1   = a;
    read_data_2   = b;
    functionField = f;
    exp_q.push_back({er, (er == 32'h0), eo, ei});
    name_q.push_back(nm);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] f, input logic [31:0] er,
                      input logic eo, input logic ei, input string nm);
    issue(1'b1, a, b, f, er, eo, ei, nm);
  endtask

  // Monitor: check at edge+1, then again at the negedge after the
  // inputs have moved, so outputs must be truly registered.
  initial begin
    logic [34:0] exp;
    logic [34:0] act;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {aluResult, zero, overflow, invalid};
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL %s: got res=%h z=%b o=%b i=%b want res=%h z=%b o=%b i=%b",
                   nm, act[34:3], act[2], act[1], act[0],
                   exp[34:3], exp[2], exp[1], exp[0]);
        end
        @(negedge clk);
        act = {aluResult, zero, overflow, invalid};
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL %s_hold: got res=%h z=%b o=%b i=%b want res=%h z=%b o=%b i=%b",
                   nm, act[34:3], act[2], act[1], act[0],
                   exp[34:3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    read_data_1   = '0;
    read_data_2   = '0;
    functionField = '0;

    issue(1'b0, 32'h0, 32'h0, 6'b100000, 32'h0, 1'b0, 1'b0, "reset");

    send(32'h00435020, 32'h00675021, 6'b100000, 32'h00AAA041, 1'b0, 1'b0, "add");
    send(32'h7FFFFFFF, 32'h00000001, 6'b100000, 32'h80000000, 1'b1, 1'b0, "add_ovf");
    send(32'h7FFFFFFF, 32'h00000001, 6'b100001, 32'h80000000, 1'b0, 1'b0, "addu");
    send(32'h80000000, 32'h80000000, 6'b100000, 32'h00000000, 1'b1, 1'b0, "add_negovf");
    send(32'h12345678, 32'h12345678, 6'b100010, 32'h00000000, 1'b0, 1'b0, "sub_zero");
    send(32'h00000005, 32'h00000007, 6'b100010, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_neg");
    send(32'h80000000, 32'h00000001, 6'b100010, 32'h7FFFFFFF, 1'b1, 1'b0, "sub_ovf");
    send(32'h80000000, 32'h00000001, 6'b100011, 32'h7FFFFFFF, 1'b0, 1'b0, "subu");
    send(32'hFFFFFFFF, 32'h00000001, 6'b101010, 32'h00000001, 1'b0, 1'b0, "slt");
    send(32'hFFFFFFFF, 32'h00000001, 6'b101011, 32'h00000000, 1'b0, 1'b0, "sltu");
    send(32'hF0F0F0F0, 32'h0FF00FF0, 6'b100100, 32'h00F000F0, 1'b0, 1'b0, "and");
    send(32'hF0F0F0F0, 32'h0FF00FF0, 6'b100101, 32'hFFF0FFF0, 1'b0, 1'b0, "or");
    send(32'hF0F0F0F0, 32'h0FF00FF0, 6'b100111, 32'h000F000F, 1'b0, 1'b0, "nor");
    send(32'hF0F0F0F0, 32'h0FF00FF0, 6'b100110, 32'hFF00FF00, 1'b0, 1'b0, "xor");

`ifdef ALU_SHIFT_EN
    send(32'h00000004, 32'h80000001, 6'b000100, 32'h00000010, 1'b0, 1'b0, "sllv");
    send(32'h00000004, 32'h80000001, 6'b000110, 32'h08000000, 1'b0, 1'b0, "srlv");
    send(32'h00000004, 32'h80000001, 6'b000111, 32'hF8000000, 1'b0, 1'b0, "srav");
    send(32'hFFFFFFE4, 32'h80000001, 6'b000111, 32'hF8000000, 1'b0, 1'b0, "srav_hi_a");
    send(32'h0000001F, 32'h00000001, 6'b000100, 32'h80000000, 1'b0, 1'b0, "sllv_31");
`else
    send(32'h00000004, 32'h80000001, 6'b000100, 32'h00000000, 1'b0, 1'b1, "sllv_off");
    send(32'h00000004, 32'h80000001, 6'b000110, 32'h00000000, 1'b0, 1'b1, "srlv_off");
    send(32'h00000004, 32'h80000001, 6'b000111, 32'h00000000, 1'b0, 1'b1, "srav_off");
`endif

    send(32'h00000004, 32'h80000001, 6'b111111, 32'h00000000, 1'b0, 1'b1, "invalid");
    send(32'h7FFFFFFF, 32'h00000001, 6'b100000, 32'h80000000, 1'b1, 1'b0, "pre_rst");
    issue(1'b0, 32'h7FFFFFFF, 32'h00000001, 6'b100000,
          32'h00000000, 1'b0, 1'b0, "mid_rst");
    send(32'h7FFFFFFF, 32'h00000001, 6'b100000, 32'h80000000, 1'b1, 1'b0, "post_rst");
    send(32'h00000001, 32'h00000002, 6'b100001, 32'h00000003, 1'b0, 1'b0, "addu_small");

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending=%0d want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Single-cycle-latency 32-bit integer ALU for the MIPS-style datapath. It sits between the register file read ports and the write-back mux. It decodes the 6-bit R-type function field, computes the result of the two register operands, and registers the result together with zero and overflow status flags.

## Interface
- No parameters; data width is fixed at 32 bits and function width at 6 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: synchronous, active-low.
- read_data_1  input  32  operand A (rs); its bits [4:0] are the shift amount for variable shifts.
- read_data_2  input  32  operand B (rt).
- functionField  input  6  R-type funct code selecting the operation.
- aluResult  output  32  registered result.
- zero  output  1  registered; 1 when the registered aluResult is 0.
- overflow  output  1  registered; signed overflow of add/sub.
- invalid  output  1  registered; 1 when functionField is unsupported.

## Operation
- Function codes (binary):
  - 100000 add: A+B, sets overflow on signed overflow.
  - 100001 addu: A+B, overflow=0.
  - 100010 sub: A−B, sets overflow on signed overflow.
  - 100011 subu: A−B, overflow=0.
  - 100100 and.
  - 100101 or.
  - 100110 xor.
  - 100111 nor: ~(A|B).
  - 101010 slt: signed A<B gives 1, else 0.
  - 101011 sltu: unsigned compare, same encoding.
  - 000100 sllv: B << A[4:0].
  - 000110 srlv: logical right shift.
  - 000111 srav: arithmetic right shift. All three shifts exist only under ALU_SHIFT_EN.
- Arithmetic wraps modulo 2^32. The result is written even when overflow=1; no trap.
- Signed overflow rule:
  - add: operands have the same sign and the result sign differs.
  - sub: operands have different signs and the result sign differs from A.
- Unsupported code: aluResult=0, zero=1, overflow=0, invalid=1.
- Shift amount uses A[4:0] only; A[31:5] are ignored.

## Timing
- The combinational result is captured on every rising clk edge; latency is exactly 1 cycle. There is no enable and no handshake.
- Reset: when rst_n=0 at a rising edge, outputs become aluResult=0, zero=1, overflow=0, invalid=0. Reset has priority over any operation.
- Deasserting rst_n mid-stream: the first edge with rst_n=1 registers the current inputs.
- Input changes between edges have no effect on outputs until the next edge.

## Configuration
- ALU_SHIFT_EN defined: sllv, srlv and srav are decoded as above.
- ALU_SHIFT_EN undefined: codes 000100, 000110 and 000111 are treated as unsupported (result 0, invalid=1), and no shifter logic is generated.

## Structure
- alu_pkg holds:
  - localparams for every funct code (FN_ADD, FN_ADDU, … FN_SRAV);
  - a 32-bit data width constant;
  - a 6-bit funct width constant.
- One natural sub-module, alu_shifter: a combinational 32-bit barrel shifter covering sllv, srlv and srav. It is instantiated only under ALU_SHIFT_EN.
- Top level contains the decode, the adder/subtractor with overflow detection, the logic unit, the compare logic and the output registers.

## Test plan
- add: A=0x00435020, B=0x00675021, funct=100000 → aluResult=0x00AAA041 one cycle later; zero=0, overflow=0, invalid=0.
- add overflow: A=0x7FFFFFFF, B=0x00000001, funct=100000 → aluResult=0x80000000, overflow=1. Same operands with addu → overflow=0.
- sub to zero, then sub negative:
  - A=B=0x12345678, funct=100010 → aluResult=0, zero=1.
  - A=5, B=7 → aluResult=0xFFFFFFFE.
- Compares and logic:
  - A=0xFFFFFFFF, B=1: slt → 1, sltu → 0.
  - A=0xF0F0F0F0, B=0x0FF00FF0: nor → 0x000F000F; xor → 0xFF00FF00.
- Shifts (ALU_SHIFT_EN defined): A=4, B=0x80000001:
  - sllv → 0x00000010;
  - srlv → 0x08000000;
  - srav → 0xF8000000.
  - With the macro undefined, the same stimulus → aluResult=0, invalid=1.
- Reset and invalid code:
  - Drive a nonzero add result, then assert rst_n=0 for one edge → aluResult=0, zero=1, overflow=0, invalid=0. Release, and the next edge registers current inputs.
  - funct=111111 → aluResult=0, invalid=1.
